// File: rtl/counter_sequencer_if.sv
// Command port of counter_sequencer: valid/ready handshake carrying one counter run request.
interface counter_sequencer_if #(
    parameter int COUNT_WIDTH = 4,
    parameter int LEN_WIDTH   = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_type;
    logic                   cmd_dir;
    logic [COUNT_WIDTH-1:0] cmd_load_val;
    logic [LEN_WIDTH-1:0]   cmd_len;

    modport master (
        output cmd_valid, cmd_type, cmd_dir, cmd_load_val, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_dir, cmd_load_val, cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sequencer.sv
// Drives one up/down counter through a load cycle and N enabled count cycles per command.
// Define COUNTER_SEQ_QUEUE_EN to add a 2-entry command FIFO in front of the sequencer FSM.
module counter_sequencer #(
    parameter int COUNT_WIDTH = 4,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset_,
    counter_sequencer_if.slave     cmd,
    input  logic                   abort,
    output logic                   cnt_load_,
    output logic [COUNT_WIDTH-1:0] cnt_load_val,
    output logic [1:0]             cnt_count_type,
    output logic                   cnt_count_dir,
    output logic                   cnt_count_enable_,
    input  logic [COUNT_WIDTH-1:0] cnt_count,
    output logic                   busy,
    output logic                   done,
    output logic                   done_abort,
    output logic [COUNT_WIDTH-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0]             ctype;
        logic                   dir;
        logic [COUNT_WIDTH-1:0] loadVal;
        logic [LEN_WIDTH-1:0]   len;
    } cmd_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   step_q, step_d;
    logic                   abort_q, abort_d;
    logic [1:0]             type_q;
    logic                   dir_q;
    logic [COUNT_WIDTH-1:0] loadVal_q;
    logic [COUNT_WIDTH-1:0] doneCount_q;

    cmd_t portCmd;
    cmd_t takeData;
    logic accept;
    logic takeCmd;

    assign portCmd = '{ctype: cmd.cmd_type, dir: cmd.cmd_dir,
                       loadVal: cmd.cmd_load_val, len: cmd.cmd_len};
    assign accept  = cmd.cmd_valid && cmd.cmd_ready;

`ifdef COUNTER_SEQ_QUEUE_EN
    cmd_t       fifo_q [2];
    logic       wrPtr_q, rdPtr_q;
    logic [1:0] count_q;
    logic       fifoEmpty, direct, push, pop;

    // An empty FIFO in IDLE hands the port command straight to LOAD so queueing adds no latency.
    assign fifoEmpty     = (count_q == 2'd0);
    assign cmd.cmd_ready = (count_q != 2'd2);
    assign direct        = accept && fifoEmpty && (state_q == IDLE);
    assign push          = accept && !direct;
    assign pop           = !fifoEmpty && ((state_q == IDLE) || (state_q == DONE));
    assign takeCmd       = pop || direct;
    assign takeData      = fifoEmpty ? portCmd : fifo_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wrPtr_q] <= portCmd;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wrPtr_q <= !wrPtr_q;
            if (pop)  rdPtr_q <= !rdPtr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    assign cmd.cmd_ready = (state_q == IDLE);
    assign takeCmd       = accept;
    assign takeData      = portCmd;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: if (takeCmd) state_d = LOAD;
            LOAD: state_d = (step_q != '0) ? RUN : DONE;
            RUN: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    step_d = step_q - LEN_WIDTH'(1);
                    if (step_q == LEN_WIDTH'(1)) state_d = DONE;
                end
            end
            DONE: state_d = takeCmd ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        // takeCmd only occurs in IDLE/DONE, so it never collides with a RUN step update.
        if (takeCmd) begin
            step_d  = takeData.len;
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            step_q      <= '0;
            abort_q     <= 1'b0;
            type_q      <= 2'd0;
            dir_q       <= 1'b1;
            loadVal_q   <= '0;
            doneCount_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            abort_q <= abort_d;
            if (takeCmd) begin
                type_q    <= takeData.ctype;
                dir_q     <= takeData.dir;
                loadVal_q <= takeData.loadVal;
            end
            if (state_q == DONE) doneCount_q <= cnt_count;
        end
    end

    assign cnt_load_         = (state_q != LOAD);
    assign cnt_load_val      = loadVal_q;
    assign cnt_count_type    = type_q;
    assign cnt_count_dir     = dir_q;
    assign cnt_count_enable_ = (state_q != RUN) || abort;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign done_abort        = (state_q == DONE) && abort_q;
    assign done_count        = doneCount_q;

endmodule
